// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use interlock.
// Define ID_EX_FORWARD_EN to enable MEM/WB forwarding; without it decode interlocks on every in-flight writer.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA   = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ID_VALID,
  output logic            ID_READY,
  input  logic [RA-1:0]   ID_RS1,
  input  logic [RA-1:0]   ID_RS2,
  input  logic [1:0]      ID_USE,
  input  logic [RA-1:0]   ID_RD,
  input  logic [XLEN-1:0] ID_RDATA1,
  input  logic [XLEN-1:0] ID_RDATA2,
  input  logic [XLEN-1:0] ID_IMM,
  input  logic [XLEN-1:0] ID_PC,
  input  logic [1:0]      ID_SRC_A,
  input  logic            ID_SRC_B,
  input  logic [3:0]      ID_CONTROL,
  input  logic [2:0]      ID_CTRL,
  input  logic            FLUSH,
  input  logic [RA-1:0]   MEM_RD,
  input  logic            MEM_REGWRITE,
  input  logic            MEM_MEMREAD,
  input  logic [XLEN-1:0] MEM_RESULT,
  input  logic [RA-1:0]   WB_RD,
  input  logic            WB_REGWRITE,
  input  logic [XLEN-1:0] WB_DATA,
  output logic [XLEN-1:0] X,
  output logic [XLEN-1:0] Y,
  output logic [3:0]      CONTROL,
  output logic            EX_VALID,
  output logic [RA-1:0]   EX_RD,
  output logic [2:0]      EX_CTRL,
  output logic [XLEN-1:0] EX_STORE_DATA
);
  localparam int CTRL_REGWRITE = 2;
  localparam int CTRL_MEMREAD  = 1;

  logic            ex_valid_q;
  logic [RA-1:0]   rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0] rdata1_q, rdata2_q, imm_q, pc_q;
  logic [1:0]      src_a_q;
  logic            src_b_q;
  logic [3:0]      control_q;
  logic [2:0]      ctrl_q;

  logic            hazard;
  logic            bubble;
  logic [XLEN-1:0] op1, op2;

  // A writer with rd != 0 targeting rs; x0 is never a dependency.
  function automatic logic rs_hit(input logic [RA-1:0] rs, input logic [RA-1:0] rd, input logic wr);
    return wr && (rd != '0) && (rd == rs);
  endfunction

  function automatic logic src_wait(input logic [RA-1:0] rs);
`ifdef ID_EX_FORWARD_EN
    return rs_hit(rs, rd_q, ex_valid_q && ctrl_q[CTRL_MEMREAD]);
`else
    return rs_hit(rs, rd_q, ex_valid_q && ctrl_q[CTRL_REGWRITE]) ||
           rs_hit(rs, MEM_RD, MEM_REGWRITE) ||
           rs_hit(rs, WB_RD, WB_REGWRITE);
`endif
  endfunction

  // Handshake: ID_READY=0 means decode must hold its slot unchanged; an instruction
  // enters EX on an edge only when ID_VALID & ID_READY & ~FLUSH, otherwise a bubble does.
  always_comb begin
    hazard = ID_VALID && ((ID_USE[0] && src_wait(ID_RS1)) || (ID_USE[1] && src_wait(ID_RS2)));
    bubble = FLUSH || hazard;
  end

  assign ID_READY = ~hazard;

  always_ff @(posedge CLK) begin
    if (RST || bubble) begin
      ex_valid_q <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      src_a_q    <= '0;
      src_b_q    <= 1'b0;
      control_q  <= '0;
      ctrl_q     <= '0;
    end else begin
      ex_valid_q <= ID_VALID;
      rs1_q      <= ID_RS1;
      rs2_q      <= ID_RS2;
      rd_q       <= ID_RD;
      rdata1_q   <= ID_RDATA1;
      rdata2_q   <= ID_RDATA2;
      imm_q      <= ID_IMM;
      pc_q       <= ID_PC;
      src_a_q    <= ID_SRC_A;
      src_b_q    <= ID_SRC_B;
      control_q  <= ID_CONTROL;
      ctrl_q     <= ID_VALID ? ID_CTRL : 3'b000;
    end
  end

`ifdef ID_EX_FORWARD_EN
  // Newest value wins: a non-load MEM result beats the WB value.
  function automatic logic [XLEN-1:0] fwd(input logic [RA-1:0] rs, input logic [XLEN-1:0] regval);
    if (rs_hit(rs, MEM_RD, MEM_REGWRITE && !MEM_MEMREAD)) return MEM_RESULT;
    if (rs_hit(rs, WB_RD, WB_REGWRITE)) return WB_DATA;
    return regval;
  endfunction

  always_comb begin
    op1 = fwd(rs1_q, rdata1_q);
    op2 = fwd(rs2_q, rdata2_q);
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{MEM_RESULT, WB_DATA, MEM_MEMREAD, rs1_q, rs2_q};

  always_comb begin
    op1 = rdata1_q;
    op2 = rdata2_q;
  end
`endif

  always_comb begin
    case (src_a_q)
      2'b00:   X = op1;
      2'b01:   X = pc_q;
      default: X = '0;
    endcase
  end

  assign Y             = src_b_q ? imm_q : op2;
  assign EX_STORE_DATA = op2;
  assign CONTROL       = control_q;
  assign EX_VALID      = ex_valid_q;
  assign EX_RD         = rd_q;
  assign EX_CTRL       = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: per-cycle vector table plus flush and reset-during-stall sequences.
// Expectations follow the ID_EX_FORWARD_EN setting of the build.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RA   = 5;
  localparam int W    = 110;
  localparam int RW   = 4;
  localparam int LD   = 6;
  localparam int ST   = 1;

  logic            CLK, RST, ID_VALID, ID_READY, ID_SRC_B, FLUSH;
  logic [RA-1:0]   ID_RS1, ID_RS2, ID_RD, MEM_RD, WB_RD, EX_RD;
  logic [1:0]      ID_USE, ID_SRC_A;
  logic [XLEN-1:0] ID_RDATA1, ID_RDATA2, ID_IMM, ID_PC, MEM_RESULT, WB_DATA;
  logic [3:0]      ID_CONTROL, CONTROL;
  logic [2:0]      ID_CTRL, EX_CTRL;
  logic            MEM_REGWRITE, MEM_MEMREAD, WB_REGWRITE, EX_VALID;
  logic [XLEN-1:0] X, Y, EX_STORE_DATA;

  id_ex_stage #(.XLEN(XLEN), .RA(RA)) dut (
    .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID), .ID_READY(ID_READY),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USE(ID_USE), .ID_RD(ID_RD),
    .ID_RDATA1(ID_RDATA1), .ID_RDATA2(ID_RDATA2), .ID_IMM(ID_IMM), .ID_PC(ID_PC),
    .ID_SRC_A(ID_SRC_A), .ID_SRC_B(ID_SRC_B), .ID_CONTROL(ID_CONTROL), .ID_CTRL(ID_CTRL),
    .FLUSH(FLUSH), .MEM_RD(MEM_RD), .MEM_REGWRITE(MEM_REGWRITE), .MEM_MEMREAD(MEM_MEMREAD),
    .MEM_RESULT(MEM_RESULT), .WB_RD(WB_RD), .WB_REGWRITE(WB_REGWRITE), .WB_DATA(WB_DATA),
    .X(X), .Y(Y), .CONTROL(CONTROL), .EX_VALID(EX_VALID), .EX_RD(EX_RD),
    .EX_CTRL(EX_CTRL), .EX_STORE_DATA(EX_STORE_DATA)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic rst; logic flush; logic valid;
    logic [RA-1:0] rs1, rs2, rd; logic [1:0] uses;
    logic [XLEN-1:0] rd1, rd2, imm, pc;
    logic [1:0] sa; logic sb; logic [3:0] control; logic [2:0] ctrl;
  } id_t;

  typedef struct {
    logic [RA-1:0] mem_rd; logic mem_rw, mem_mr; logic [XLEN-1:0] mem_res;
    logic [RA-1:0] wb_rd; logic wb_rw; logic [XLEN-1:0] wb_data;
  } side_t;

  // dc=1: only valid/ctrl/rd/control are defined (bubble); X/Y/store are not compared.
  typedef struct {
    logic ready; logic dc; logic valid; logic [2:0] ctrl; logic [RA-1:0] rd; logic [3:0] control;
    logic [XLEN-1:0] x, y, st;
  } exp_t;

  typedef struct { id_t id; side_t sd; exp_t ex; } vec_t;

  vec_t            tv[$];
  logic [W-1:0]    exp_q[$];
  int              n_cmp, n_fail;

  function automatic id_t id_f(input int valid, input int rs1, input int rs2, input int uses, input int rd,
                               input int rd1, input int rd2, input int imm, input int pc,
                               input int sa, input int sb, input int control, input int ctrl);
    id_t a;
    a.rst = 1'b0; a.flush = 1'b0; a.valid = 1'(valid);
    a.rs1 = 5'(rs1); a.rs2 = 5'(rs2); a.uses = 2'(uses); a.rd = 5'(rd);
    a.rd1 = 32'(rd1); a.rd2 = 32'(rd2); a.imm = 32'(imm); a.pc = 32'(pc);
    a.sa = 2'(sa); a.sb = 1'(sb); a.control = 4'(control); a.ctrl = 3'(ctrl);
    return a;
  endfunction

  function automatic side_t sd_f(input int mrd, input int mrw, input int mmr, input int mres,
                                 input int wrd, input int wrw, input int wdata);
    side_t s;
    s.mem_rd = 5'(mrd); s.mem_rw = 1'(mrw); s.mem_mr = 1'(mmr); s.mem_res = 32'(mres);
    s.wb_rd = 5'(wrd); s.wb_rw = 1'(wrw); s.wb_data = 32'(wdata);
    return s;
  endfunction

  function automatic exp_t ex_f(input int ready, input int valid, input int ctrl, input int rd,
                                input int control, input int x, input int y, input int st);
    exp_t e;
    e.ready = 1'(ready); e.dc = 1'b0; e.valid = 1'(valid); e.ctrl = 3'(ctrl); e.rd = 5'(rd);
    e.control = 4'(control); e.x = 32'(x); e.y = 32'(y); e.st = 32'(st);
    return e;
  endfunction

  function automatic exp_t bub_f(input int ready);
    exp_t e;
    e = ex_f(ready, 0, 0, 0, 0, 0, 0, 0);
    e.dc = 1'b1;
    return e;
  endfunction

  function automatic id_t idle_id();
    return id_f(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic side_t idle_sd();
    return sd_f(0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [W-1:0] pack_exp(input exp_t e);
    return {e.dc, e.valid, e.ctrl, e.rd, e.control, e.x, e.y, e.st};
  endfunction

  task automatic add_row(input id_t a, input side_t s, input exp_t e);
    vec_t v;
    v.id = a; v.sd = s; v.ex = e;
    tv.push_back(v);
  endtask

  // Driver
  task automatic drive(input id_t a, input side_t s);
    RST = a.rst; FLUSH = a.flush; ID_VALID = a.valid;
    ID_RS1 = a.rs1; ID_RS2 = a.rs2; ID_USE = a.uses; ID_RD = a.rd;
    ID_RDATA1 = a.rd1; ID_RDATA2 = a.rd2; ID_IMM = a.imm; ID_PC = a.pc;
    ID_SRC_A = a.sa; ID_SRC_B = a.sb; ID_CONTROL = a.control; ID_CTRL = a.ctrl;
    MEM_RD = s.mem_rd; MEM_REGWRITE = s.mem_rw; MEM_MEMREAD = s.mem_mr; MEM_RESULT = s.mem_res;
    WB_RD = s.wb_rd; WB_REGWRITE = s.wb_rw; WB_DATA = s.wb_data;
  endtask

  // Scoreboard check
  task automatic check(input exp_t e, input string tag);
    logic [W-1:0] want, got;
    n_cmp++;
    if (ID_READY !== e.ready) begin
      n_fail++;
      $display("FAIL %s id_ready: got %b want %b", tag, ID_READY, e.ready);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s ex: no expected entry queued", tag);
    end else begin
      want = exp_q.pop_front();
      got  = {want[W-1], EX_VALID, EX_CTRL, EX_RD, CONTROL, X, Y, EX_STORE_DATA};
      if (want[W-1]) begin
        got[95:0]  = '0;
        want[95:0] = '0;
      end
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s ex: got valid=%b ctrl=%b rd=%0d op=%b x=%h y=%h st=%h want valid=%b ctrl=%b rd=%0d op=%b x=%h y=%h st=%h",
                 tag, got[108], got[107:105], got[104:100], got[99:96], got[95:64], got[63:32], got[31:0],
                 want[108], want[107:105], want[104:100], want[99:96], want[95:64], want[63:32], want[31:0]);
      end
    end
  endtask

  // One cycle: drive just after posedge, compare at negedge, advance.
  task automatic step(input vec_t v, input string tag);
    drive(v.id, v.sd);
    exp_q.push_back(pack_exp(v.ex));
    @(negedge CLK);
    check(v.ex, tag);
    @(posedge CLK);
    #1;
  endtask

  task automatic build_table();
    id_t sub_i, add8_i;
`ifdef ID_EX_FORWARD_EN
    add_row(id_f(1, 1, 2, 3, 5, 3, 4, 0, 'h100, 0, 0, 0, RW), idle_sd(), bub_f(1));
    add_row(id_f(1, 5, 1, 3, 6, 0, 3, 0, 'h104, 0, 0, 'b0111, RW), idle_sd(), ex_f(1, 1, RW, 5, 0, 3, 4, 4));
    add_row(idle_id(), sd_f(5, 1, 0, 7, 0, 0, 0), ex_f(1, 1, RW, 6, 'b0111, 7, 3, 3));
    add_row(id_f(1, 5, 5, 3, 9, 1, 1, 0, 'h108, 0, 0, 0, RW), sd_f(6, 1, 0, 4, 5, 1, 7), bub_f(1));
    add_row(id_f(1, 0, 0, 3, 10, 0, 0, 0, 'h10c, 0, 0, 0, RW), sd_f(5, 1, 0, 9, 5, 1, 2), ex_f(1, 1, RW, 9, 0, 9, 9, 9));
    add_row(id_f(1, 0, 0, 1, 7, 0, 0, 'h40, 'h110, 0, 1, 0, LD), sd_f(0, 1, 0, 9, 0, 1, 2), ex_f(1, 1, RW, 10, 0, 0, 0, 0));
    add8_i = id_f(1, 7, 7, 3, 8, 0, 0, 0, 'h114, 0, 0, 0, RW);
    add_row(add8_i, idle_sd(), ex_f(0, 1, LD, 7, 0, 0, 'h40, 0));
    add_row(add8_i, sd_f(7, 1, 1, 'h40, 0, 0, 0), bub_f(1));
    add_row(idle_id(), sd_f(7, 1, 1, 'h99, 7, 1, 'h55), ex_f(1, 1, RW, 8, 0, 'h55, 'h55, 'h55));
    add_row(id_f(1, 3, 4, 3, 11, 'h10, 'h20, 'h8, 'h118, 1, 1, 'b0011, ST), idle_sd(), bub_f(1));
    add_row(idle_id(), sd_f(4, 1, 0, 'h44, 3, 1, 'h33), ex_f(1, 1, ST, 11, 'b0011, 'h118, 'h8, 'h44));
    add_row(idle_id(), idle_sd(), bub_f(1));
`else
    add_row(id_f(1, 1, 2, 3, 5, 3, 4, 0, 'h100, 0, 0, 0, RW), idle_sd(), bub_f(1));
    sub_i = id_f(1, 5, 1, 3, 6, 0, 3, 0, 'h104, 0, 0, 'b0111, RW);
    add_row(sub_i, idle_sd(), ex_f(0, 1, RW, 5, 0, 3, 4, 4));
    add_row(sub_i, sd_f(5, 1, 0, 7, 0, 0, 0), bub_f(0));
    add_row(sub_i, sd_f(0, 0, 0, 0, 5, 1, 7), bub_f(0));
    sub_i.rd1 = 32'h7;
    add_row(sub_i, idle_sd(), bub_f(1));
    add_row(id_f(1, 0, 0, 0, 9, 'hdead, 'hbeef, 'h1000, 'h108, 1, 1, 0, RW), idle_sd(),
            ex_f(1, 1, RW, 6, 'b0111, 7, 3, 3));
    add_row(id_f(1, 0, 0, 1, 7, 0, 0, 8, 'h10c, 0, 1, 0, LD), sd_f(6, 1, 0, 4, 0, 0, 0),
            ex_f(1, 1, RW, 9, 0, 'h108, 'h1000, 'hbeef));
    add8_i = id_f(1, 7, 7, 3, 8, 0, 0, 0, 'h110, 0, 0, 0, RW);
    add_row(add8_i, sd_f(9, 1, 0, 'h1108, 6, 1, 4), ex_f(0, 1, LD, 7, 0, 0, 8, 0));
    add_row(add8_i, sd_f(7, 1, 1, 8, 9, 1, 'h1108), bub_f(0));
    add_row(add8_i, sd_f(0, 0, 0, 0, 7, 1, 'h55), bub_f(0));
    add8_i.rd1 = 32'h55; add8_i.rd2 = 32'h55;
    add_row(add8_i, idle_sd(), bub_f(1));
    add_row(id_f(0, 8, 0, 1, 0, 'h1234, 'h5678, 0, 'h200, 1, 0, 0, 7), idle_sd(),
            ex_f(1, 1, RW, 8, 0, 'h55, 'h55, 'h55));
    add_row(id_f(1, 3, 8, 1, 10, 'h11, 'h22, 0, 'h204, 2, 0, 'b0101, ST), sd_f(8, 1, 0, 'haa, 0, 0, 0), bub_f(1));
    add_row(id_f(1, 10, 0, 3, 0, 5, 6, 0, 'h208, 0, 0, 'b0001, RW), sd_f(0, 0, 0, 0, 8, 1, 'haa),
            ex_f(1, 1, ST, 10, 'b0101, 0, 'h22, 'h22));
    add_row(id_f(1, 0, 0, 3, 11, 0, 0, 'hfffffff0, 'h20c, 0, 1, 'b0010, RW), sd_f(10, 0, 0, 'h33, 0, 0, 0),
            ex_f(1, 1, RW, 0, 'b0001, 5, 6, 6));
    add_row(idle_id(), sd_f(0, 1, 0, 'h77, 10, 0, 0), ex_f(1, 1, RW, 11, 'b0010, 0, 'hfffffff0, 0));
    add_row(idle_id(), idle_sd(), bub_f(1));
    add_row(id_f(1, 0, 13, 2, 14, 0, 0, 0, 'h300, 0, 0, 0, RW), sd_f(0, 0, 0, 0, 13, 1, 'h99), bub_f(0));
    add_row(id_f(1, 0, 13, 2, 14, 0, 'h99, 0, 'h300, 0, 0, 0, RW), idle_sd(), bub_f(1));
    add_row(idle_id(), idle_sd(), ex_f(1, 1, RW, 14, 0, 0, 'h99, 'h99));
`endif
  endtask

  initial begin
    vec_t v;
    id_t  lw_i, add_i;
    n_cmp = 0;
    n_fail = 0;

    v.id = id_f(1, 32'($urandom_range(31, 0)), 32'($urandom_range(31, 0)), 3, 32'($urandom_range(31, 0)),
                32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
                32'($urandom_range(3, 0)), 32'($urandom_range(1, 0)), 32'($urandom_range(15, 0)), 7);
    v.id.rst = 1'b1;
    v.sd = idle_sd();
    drive(v.id, v.sd);
    repeat (2) @(posedge CLK);
    #1;
    v.id.rst = 1'b0;
    v.id.flush = 1'b1;
    v.ex = ex_f(1, 0, 0, 0, 0, 0, 0, 0);
    step(v, "reset");

    build_table();
    foreach (tv[i]) step(tv[i], $sformatf("row%0d", i));

    // FLUSH lands while a load-use stall is pending; the dependent ADD must not reach EX.
    lw_i  = id_f(1, 0, 0, 1, 7, 0, 0, 4, 'h400, 0, 1, 0, LD);
    add_i = id_f(1, 7, 7, 3, 8, 0, 0, 0, 'h404, 0, 0, 0, RW);
    v.id = lw_i; v.sd = idle_sd(); v.ex = bub_f(1);
    step(v, "flush_lw");
    v.id = add_i; v.id.flush = 1'b1; v.ex = ex_f(0, 1, LD, 7, 0, 0, 4, 0);
    step(v, "flush_stall");
    v.id = idle_id(); v.sd = sd_f(7, 1, 1, 4, 0, 0, 0); v.ex = bub_f(1);
    step(v, "flush_bubble");
    v.id = idle_id(); v.sd = sd_f(0, 0, 0, 0, 7, 1, 'h55); v.ex = bub_f(1);
    step(v, "flush_nodup");

    // Reset asserted during a load-use stall clears the stall.
    v.id = lw_i; v.sd = idle_sd(); v.ex = bub_f(1);
    step(v, "rst_lw");
    v.id = add_i; v.id.rst = 1'b1; v.ex = ex_f(0, 1, LD, 7, 0, 0, 4, 0);
    step(v, "rst_stall");
    v.id = add_i; v.id.rd1 = 32'h55; v.id.rd2 = 32'h55; v.ex = ex_f(1, 0, 0, 0, 0, 0, 0, 0);
    step(v, "rst_cleared");
    v.id = idle_id(); v.ex = ex_f(1, 1, RW, 8, 0, 'h55, 'h55, 'h55);
    step(v, "rst_resume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and load-use interlock for the 5-stage RISC-V core.
- Captures decoded operands each cycle and drives the ALU inputs X, Y and CONTROL combinationally from the registered fields, with forwarding from the MEM and WB stages.
- Drives ID_READY low to stall decode, and inserts bubbles on stall or FLUSH.

Parameters:
XLEN, 32, datapath width
RA, 5, register-address width

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
ID_VALID  in  1  decode slot holds a real instruction
ID_READY  out  1  stage accepts ID instruction this edge (0 = stall decode)
ID_RS1  in  RA  source register 1
ID_RS2  in  RA  source register 2
ID_USE  in  2  [0]=reads rs1, [1]=reads rs2
ID_RD  in  RA  destination register
ID_RDATA1  in  XLEN  regfile read data rs1
ID_RDATA2  in  XLEN  regfile read data rs2
ID_IMM  in  XLEN  sign-extended immediate
ID_PC  in  XLEN  instruction PC
ID_SRC_A  in  2  X select: 00 rs1, 01 PC, 10/11 zero
ID_SRC_B  in  1  Y select: 0 rs2, 1 imm
ID_CONTROL  in  4  ALU operation code
ID_CTRL  in  3  {REGWRITE, MEMREAD, MEMWRITE}
FLUSH  in  1  taken branch/jump: kill instruction entering EX
MEM_RD  in  RA  MEM-stage destination
MEM_REGWRITE  in  1  MEM-stage writes rd
MEM_MEMREAD  in  1  MEM-stage is a load
MEM_RESULT  in  XLEN  MEM-stage ALU result
WB_RD  in  RA  WB-stage destination
WB_REGWRITE  in  1  WB-stage writes rd
WB_DATA  in  XLEN  WB write-back value
X  out  XLEN  ALU operand X
Y  out  XLEN  ALU operand Y
CONTROL  out  4  ALU operation code
EX_VALID  out  1  EX holds a real instruction
EX_RD  out  RA  registered rd
EX_CTRL  out  3  registered {REGWRITE, MEMREAD, MEMWRITE}, zero in bubble
EX_STORE_DATA  out  XLEN  forwarded rs2, used for SW

Behaviour:
- Reset (RST=1 at edge): all registers are cleared. EX_VALID=0, EX_CTRL=0, EX_RD=0 and CONTROL=0. X=Y=0 and EX_STORE_DATA=0, provided MEM/WB are idle. ID_READY=1 from the first cycle after reset. Reset mid-stall clears the stall.
- Load-use hazard:
  - Condition: ID_VALID & EX_VALID & EX_CTRL.MEMREAD & EX_RD≠0 & ((ID_USE[0] & ID_RS1==EX_RD) | (ID_USE[1] & ID_RS2==EX_RD)).
  - ID_READY = ~hazard, combinational.
  - On a hazard edge, a bubble is loaded into EX. Decode holds its inputs.
  - The stall lasts exactly 1 cycle.
- Edge priority: RST > FLUSH > hazard > normal load.
  - FLUSH loads a bubble regardless of hazard.
  - ID_READY stays combinational. Decode must also discard its slot on FLUSH.
- Bubble: EX_VALID=0, EX_CTRL=0, EX_RD=0, CONTROL=0. The other fields are don't-care.
- Normal load: all ID fields are registered. EX_VALID ← ID_VALID. EX_CTRL is zeroed if ID_VALID=0.
- Forwarding for each registered rs (rs1, rs2), applied in EX:
  - If rs≠0 & MEM_REGWRITE & ~MEM_MEMREAD & MEM_RD==rs → MEM_RESULT.
  - Else if rs≠0 & WB_REGWRITE & WB_RD==rs → WB_DATA.
  - Else the registered regfile data.
  - MEM has priority over WB (newest value wins). x0 is never forwarded.
- Operand mux: X from SRC_A using the forwarded rs1. Y from SRC_B using the forwarded rs2 or IMM. EX_STORE_DATA is always the forwarded rs2.
- Latency: 1 cycle from ID capture to X/Y valid. Forward paths are purely combinational within EX.
- Regfile is write-first, so WB→ID needs no forwarding.

Optional Feature:
ID_EX_FORWARD_EN
- Defined: forwarding as specified above.
- Undefined:
  - No forwarding muxes; X/Y use the registered regfile data only.
  - The hazard condition is extended to any valid in-flight writer with rd≠0 matching a used rs in EX (EX_CTRL.REGWRITE), MEM (MEM_REGWRITE) or WB (WB_REGWRITE).
  - A stall therefore lasts up to 3 cycles; bubbles are inserted each stalled cycle.

Test Plan:
- Reset: RST=1 for 2 cycles with garbage on ID → EX_VALID=0, CONTROL=0, X=Y=0, ID_READY=1 after release.
- EX→EX forward: ADD x5,x1,x2 (x1=3, x2=4) then SUB x6,x5,x1 → in SUB's EX, MEM_RESULT=7 drives X=7, Y=3, CONTROL=0111, no stall.
- Priority: MEM and WB both target x5 (MEM=9, WB=2), consumer reads x5 → X=9. Same with rd=x0 → X=regfile value (0).
- Load-use: LW x7 then ADD x8,x7,x7 → ID_READY=0 for exactly 1 cycle, EX bubble (EX_CTRL=0), then X=Y=WB_DATA (0x55).
- FLUSH during a load-use stall: FLUSH=1 → bubble loaded, next cycle ID_READY=1. No instruction is duplicated and the ADD never reaches EX until re-fetched.
- Without ID_EX_FORWARD_EN: ADD x5 then a dependent SUB → 3 stall cycles, then X=7 from regfile.
